discrete_sample_mixer: RTL and testbench

DISCRETE_SAMPLE_MIXER -- requirements
Module: discrete_sample_mixer

---
 rtl/discrete_sample_mixer.sv | 118 +++++++++++
 tb/tb_discrete_sample_mixer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/discrete_sample_mixer.sv
// Multi-channel audio mixer: snapshots all channels on the sample strobe, then runs one
// signed multiply-accumulate per clk and saturates the Q1.7-scaled sum to 16 bits.
module discrete_sample_mixer #(
    parameter int NUM_INPUTS  = 4,
    parameter int CLOCK_RATE  = 1000000,
    parameter int SAMPLE_RATE = 96000
) (
    input  logic                      clk,
    input  logic                      I_RST,
    input  logic                      audio_clk_en,
    input  logic [16*NUM_INPUTS-1:0]  in,
    input  logic [8*NUM_INPUTS-1:0]   gain,
    output logic signed [15:0]        out,
    output logic                      out_valid,
    output logic                      overrun
);

    localparam int CW = $clog2(NUM_INPUTS);
    localparam int AW = 25 + $clog2(NUM_INPUTS);

    if (NUM_INPUTS < 2 || NUM_INPUTS > 8) begin : g_bad_num_inputs
        $error("discrete_sample_mixer: NUM_INPUTS must be in 2..8");
    end

    // A mix needs NUM_INPUTS+2 clocks; strobes must not arrive faster than that.
    if (CLOCK_RATE / SAMPLE_RATE < NUM_INPUTS + 2) begin : g_bad_rate
        $error("discrete_sample_mixer: CLOCK_RATE/SAMPLE_RATE must be >= NUM_INPUTS+2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StSat
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic signed [AW-1:0]    acc;
    logic signed [15:0]      snap_in   [NUM_INPUTS];
    logic [7:0]              snap_gain [NUM_INPUTS];

    logic signed [24:0]      in_ext;
    logic signed [24:0]      gain_ext;
    logic signed [24:0]      prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [AW-8:0]    shifted;
    logic signed [15:0]      sat_val;

    // Gain is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        in_ext   = 25'(snap_in[cnt]);
        gain_ext = {17'd0, snap_gain[cnt]};
        prod     = in_ext * gain_ext;
        prod_ext = {{(AW - 25){prod[24]}}, prod};
    end

    // Dropping the low 7 bits of a two's-complement value floors toward minus infinity.
    always_comb begin
        shifted = acc[AW-1:7];
        if (shifted[AW-8:15] == {(AW - 22){1'b0}} || shifted[AW-8:15] == {(AW - 22){1'b1}}) begin
            sat_val = shifted[15:0];
        end else if (shifted[AW-8]) begin
            sat_val = 16'sh8000;
        end else begin
            sat_val = 16'sh7fff;
        end
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state     <= StIdle;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                snap_in[k]   <= '0;
                snap_gain[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (audio_clk_en) begin
                        for (int k = 0; k < NUM_INPUTS; k++) begin
                            snap_in[k]   <= in[16*k +: 16];
                            snap_gain[k] <= gain[8*k +: 8];
                        end
                        acc   <= '0;
                        cnt   <= '0;
                        state <= StAccum;
                    end
                end
                StAccum: begin
                    acc <= acc + prod_ext;
                    if (audio_clk_en) begin
                        overrun <= 1'b1;
                    end
                    if (cnt == CW'(NUM_INPUTS - 1)) begin
                        cnt   <= '0;
                        state <= StSat;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StSat: begin
                    // A strobe landing on this cycle is dropped without flagging overrun.
                    out       <= sat_val;
                    out_valid <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_sample_mixer.sv
// Scoreboard bench for discrete_sample_mixer: stimulus pushes expected mixes, a monitor
// pops them on out_valid and also tracks out hold and the sticky overrun flag.
module tb_discrete_sample_mixer;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 I_RST;
    logic                 audio_clk_en;
    logic [16*N-1:0]      in_v;
    logic [8*N-1:0]       gain_v;
    logic signed [15:0]   out;
    logic                 out_valid;
    logic                 overrun;

    discrete_sample_mixer #(
        .NUM_INPUTS  (N),
        .CLOCK_RATE  (1000000),
        .SAMPLE_RATE (96000)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .in           (in_v),
        .gain         (gain_v),
        .out          (out),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t         q[$];
    exp_t         e;
    int           cyc      = 0;
    int           vectors  = 0;
    int           errors   = 0;
    int           exp_out  = 0;
    bit           exp_ovr  = 1'b0;
    int           acc_at   = -1000;
    logic [15:0]  mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference mix: plain integer sum of products, floor-divide by 128, clamp.
    function automatic int mix(input logic [16*N-1:0] vi, input logic [8*N-1:0] vg);
        longint             acc;
        logic signed [15:0] s;
        logic [7:0]         g;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            s = vi[16*k +: 16];
            g = vg[8*k +: 8];
            acc += longint'(s) * longint'(g);
        end
        acc = acc >>> 7;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    task automatic set_ch(input int k, input int v, input int g);
        in_v[16*k +: 16] = 16'(v);
        gain_v[8*k +: 8] = 8'(g);
    endtask

    // One clock of stimulus; classifies a strobe by where it lands relative to the last
    // accepted mix: channels busy for N cycles, one saturate cycle, then idle.
    task automatic cycle_op(input bit stb, input bit rnd);
        logic [16*N-1:0] ci;
        logic [8*N-1:0]  cg;
        int              s;
        @(negedge clk);
        audio_clk_en = stb;
        if (rnd) begin
            in_v   = {$urandom, $urandom};
            gain_v = $urandom;
        end
        ci = in_v;
        cg = gain_v;
        @(posedge clk);
        #1;
        if (stb) begin
            s = cyc;
            if (s >= acc_at + 1 && s <= acc_at + N) begin
                exp_ovr = 1'b1;
            end else if (s != acc_at + N + 1) begin
                acc_at = s;
                q.push_back('{mix(ci, cg), s + N + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, 1'b0);
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, req);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #2;
            vectors++;
            if (overrun !== exp_ovr) begin
                errors++;
                $display("FAIL overrun: got %b want %b at cyc %0d", overrun, exp_ovr, cyc);
            end
            vectors++;
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected out_valid at cyc %0d (out=%0d)", cyc, out);
                end else begin
                    e = q.pop_front();
                    mon_exp = 16'(e.val);
                    if (out !== mon_exp || cyc != e.due) begin
                        errors++;
                        $display("FAIL mix: got %0d at cyc %0d want %0d at cyc %0d",
                                 out, cyc, e.val, e.due);
                    end
                    exp_out = e.val;
                end
            end else begin
                mon_exp = 16'(exp_out);
                if (out !== mon_exp) begin
                    errors++;
                    $display("FAIL out hold: got %0d want %0d at cyc %0d", out, exp_out, cyc);
                end
            end
        end
    end

    initial begin
        I_RST        = 1'b1;
        audio_clk_en = 1'b0;
        in_v         = '0;
        gain_v       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset out_valid", out_valid, 1'b0);
        check_bit("reset overrun", overrun, 1'b0);
        check_bit("reset out zero", (out == 16'sd0), 1'b1);
        @(negedge clk);
        I_RST = 1'b0;
        idle(2);

        // Basic unity-gain mix and saturation in both directions
        set_ch(0, 1000, 128); set_ch(1, -2000, 128); set_ch(2, 3000, 128); set_ch(3, 4000, 128);
        cycle_op(1'b1, 1'b0); idle(N + 3);
        set_ch(0, 20000, 128); set_ch(1, 20000, 128); set_ch(2, 20000, 128); set_ch(3, 0, 128);
        cycle_op(1'b1, 1'b0); idle(N + 3);
        set_ch(0, -20000, 128); set_ch(1, -20000, 128); set_ch(2, -20000, 128);
        cycle_op(1'b1, 1'b0); idle(N + 3);

        // Half gain with floor rounding on a negative sample
        set_ch(0, 1000, 64); set_ch(1, 7, 0); set_ch(2, -9, 0); set_ch(3, 123, 0);
        cycle_op(1'b1, 1'b0); idle(N + 3);
        set_ch(0, -3, 64);
        cycle_op(1'b1, 1'b0); idle(N + 3);

        // All gains muted
        in_v   = {$urandom, $urandom};
        gain_v = '0;
        cycle_op(1'b1, 1'b0); idle(N + 3);

        // Inputs churning during the mix must not leak in
        in_v   = {$urandom, $urandom};
        gain_v = $urandom;
        cycle_op(1'b1, 1'b0);
        for (int i = 0; i < N + 2; i++) cycle_op(1'b0, 1'b1);
        idle(2);

        // Strobe on the saturate cycle: dropped, no overrun
        cycle_op(1'b1, 1'b1); idle(N);
        cycle_op(1'b1, 1'b1); idle(N + 4);

        // Strobe two cycles into a mix: overrun sticks through later mixes
        cycle_op(1'b1, 1'b1); cycle_op(1'b0, 1'b0); cycle_op(1'b1, 1'b1); idle(N + 3);
        cycle_op(1'b1, 1'b1); idle(N + 3);

        // Random strobe spacing
        for (int i = 0; i < 150; i++) cycle_op(($urandom_range(0, 3) == 0), 1'b1);
        idle(N + 3);

        // Reset mid-mix aborts with no pulse and clears overrun
        cycle_op(1'b1, 1'b1); cycle_op(1'b0, 1'b1); cycle_op(1'b0, 1'b1);
        @(negedge clk);
        I_RST = 1'b1;
        #1;
        check_bit("mid-mix reset out_valid", out_valid, 1'b0);
        check_bit("mid-mix reset overrun", overrun, 1'b0);
        check_bit("mid-mix reset out zero", (out == 16'sd0), 1'b1);
        q.delete();
        exp_out = 0;
        exp_ovr = 1'b0;
        acc_at  = -1000;
        @(negedge clk);
        I_RST = 1'b0;
        idle(2);
        cycle_op(1'b1, 1'b1); idle(N + 3);

        for (int i = 0; i < 100; i++) cycle_op(($urandom_range(0, 4) == 0), 1'b1);
        idle(N + 4);

        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d mixes never presented, want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
